// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer and its neighbours: PC register,
// instruction memory, decode and branch resolution.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  pc_cur;
    logic [ADDR_W-1:0]  pc_next;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               fetch_fault;

    modport master (
        input  pc_cur, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               instr_ready, redirect_valid, redirect_target,
        output pc_next, imem_req_valid, imem_addr, instr_valid,
               instr_data, instr_pc, fetch_fault
    );

    modport slave (
        output pc_cur, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               instr_ready, redirect_valid, redirect_target,
        input  pc_next, imem_req_valid, imem_addr, instr_valid,
               instr_data, instr_pc, fetch_fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// RV32 instruction fetch sequencer: one outstanding word fetch, decode handoff, redirects.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being aligned.
module fetch_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [ADDR_W-1:0]  target;
    logic               req_valid;
    logic               capture_pc;
    logic               capture_data;
    logic               clear_valid;
    logic               valid_q;
    logic [INSTR_W-1:0] data_q;
    logic [ADDR_W-1:0]  ipc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign target     = bus.redirect_target;
    assign misaligned = |bus.redirect_target[1:0];
`else
    assign target = bus.redirect_target & ~ADDR_W'(3);
`endif

    always_comb begin
        state_n      = state;
        pc_n         = bus.pc_cur;
        req_valid    = 1'b0;
        capture_pc   = 1'b0;
        capture_data = 1'b0;
        clear_valid  = 1'b0;
        case (state)
            REQ: begin
                req_valid = 1'b1;
                if (bus.redirect_valid) begin
                    pc_n        = target;
                    clear_valid = 1'b1;
                    // An accepted request is now stale; its response must be drained.
                    state_n     = bus.imem_req_ready ? DRAIN : REQ;
                end else if (bus.imem_req_ready) begin
                    capture_pc = 1'b1;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_n        = target;
                    clear_valid = 1'b1;
                    state_n     = bus.imem_rsp_valid ? REQ : DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    capture_data = 1'b1;
                    pc_n         = bus.pc_cur + ADDR_W'(4);
                    state_n      = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_n        = target;
                    clear_valid = 1'b1;
                    state_n     = REQ;
                end else if (bus.instr_ready) begin
                    clear_valid = 1'b1;
                    state_n     = REQ;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) begin
                    pc_n        = target;
                    clear_valid = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    state_n = REQ;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        // A misaligned target overrides every transition above and freezes the PC.
        if (bus.redirect_valid && misaligned && state != TRAP) begin
            state_n      = TRAP;
            pc_n         = bus.pc_cur;
            capture_pc   = 1'b0;
            capture_data = 1'b0;
            clear_valid  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= REQ;
            valid_q <= 1'b0;
            data_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state <= state_n;
            if (capture_pc) begin
                ipc_q <= bus.pc_cur;
            end
            if (capture_data) begin
                data_q  <= bus.imem_rsp_data;
                valid_q <= 1'b1;
            end else if (clear_valid) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.pc_next        = reset ? '0 : pc_n;
    assign bus.imem_req_valid = req_valid & ~reset;
    assign bus.imem_addr      = bus.pc_cur;
    assign bus.instr_valid    = valid_q;
    assign bus.instr_data     = data_q;
    assign bus.instr_pc       = ipc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = (state == TRAP) & ~reset;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus a throughput sequence.
// Expectations for the misaligned redirect follow FETCH_MISALIGN_TRAP_EN.
module tb_fetch_sequencer;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        irdy;
        logic        redir;
        logic [31:0] tgt;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_id;
        logic [31:0] e_ipc;
        logic [31:0] e_pn;
        logic        e_flt;
    } vec_t;

    logic clk;
    logic reset;
    int   vectors_applied;
    int   miscompares;
    vec_t vecs[$];

    fetch_sequencer_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    fetch_sequencer #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for program_counter: pc_out follows pc_in one clock later.
    always_ff @(posedge clk) begin
        bus.pc_cur <= bus.pc_next;
    end

    function automatic logic [31:0] dw(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t mk(input logic [31:0] rst, rdy, rspv, rspd, irdy, redir, tgt,
                                input logic [31:0] reqv, addr, iv, id, ipc, pn, flt);
        vec_t v;
        v.rst    = rst[0];
        v.rdy    = rdy[0];
        v.rspv   = rspv[0];
        v.rspd   = rspd;
        v.irdy   = irdy[0];
        v.redir  = redir[0];
        v.tgt    = tgt;
        v.e_reqv = reqv[0];
        v.e_addr = addr;
        v.e_iv   = iv[0];
        v.e_id   = id;
        v.e_ipc  = ipc;
        v.e_pn   = pn;
        v.e_flt  = flt[0];
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        reset               = v.rst;
        bus.imem_req_ready  = v.rdy;
        bus.imem_rsp_valid  = v.rspv;
        bus.imem_rsp_data   = v.rspd;
        bus.instr_ready     = v.irdy;
        bus.redirect_valid  = v.redir;
        bus.redirect_target = v.tgt;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        vectors_applied++;
        if (bus.imem_req_valid !== v.e_reqv || bus.imem_addr !== v.e_addr ||
            bus.instr_valid !== v.e_iv || bus.instr_data !== v.e_id ||
            bus.instr_pc !== v.e_ipc || bus.pc_next !== v.e_pn ||
            bus.fetch_fault !== v.e_flt) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got req=%0b addr=%h iv=%0b data=%h ipc=%h next=%h fault=%0b, want req=%0b addr=%h iv=%0b data=%h ipc=%h next=%h fault=%0b",
                     idx, bus.imem_req_valid, bus.imem_addr, bus.instr_valid, bus.instr_data,
                     bus.instr_pc, bus.pc_next, bus.fetch_fault, v.e_reqv, v.e_addr, v.e_iv,
                     v.e_id, v.e_ipc, v.e_pn, v.e_flt);
        end
    endtask

    task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors_applied++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        logic [31:0] acc_addr[3];
        int          acc_cyc[3];
        logic [31:0] hand_pc[3];
        int          n_acc;
        int          n_hand;
        logic        pend;
        logic [31:0] pend_addr;

        vectors_applied = 0;
        miscompares     = 0;

        // Reset, sequential fetch and decode backpressure at 0x4
        vecs.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,dw(0),1,0,0,        0,0,0,0,0,4,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,4,1,dw(0),0,4,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,4,0,dw(0),0,4,0));
        vecs.push_back(mk(0,1,1,dw(4),1,0,0,        0,4,0,dw(0),4,8,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,0,0,0,0,        0,8,1,dw(4),4,8,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,8,1,dw(4),4,8,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,8,0,dw(4),4,8,0));
        vecs.push_back(mk(0,1,1,dw(8),1,0,0,        0,8,0,dw(4),8,'hC,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,'hC,1,dw(8),8,'hC,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,'hC,0,dw(8),8,'hC,0));
        // Redirect in WAIT, stale response drained two cycles later
        vecs.push_back(mk(0,1,0,0,1,1,'h100,        0,'hC,0,dw(8),'hC,'h100,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,'h100,0,dw(8),'hC,'h100,0));
        vecs.push_back(mk(0,1,1,'hDEAD,1,0,0,       0,'h100,0,dw(8),'hC,'h100,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,'h100,0,dw(8),'hC,'h100,0));
        vecs.push_back(mk(0,1,1,dw('h100),1,0,0,    0,'h100,0,dw(8),'h100,'h104,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,'h104,1,dw('h100),'h100,'h104,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,'h104,0,dw('h100),'h100,'h104,0));
        // Redirect coincident with response: no DRAIN
        vecs.push_back(mk(0,1,1,'hBAD,1,1,'h200,    0,'h104,0,dw('h100),'h104,'h200,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,'h200,0,dw('h100),'h104,'h200,0));
        vecs.push_back(mk(0,1,1,dw('h200),1,0,0,    0,'h200,0,dw('h100),'h200,'h204,0));
        // Redirect in HOLD beats instr_ready; wrap at top of address space
        vecs.push_back(mk(0,1,0,0,1,1,'hFFFFFFFC,   0,'h204,1,dw('h200),'h200,'hFFFFFFFC,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,            1,'hFFFFFFFC,0,dw('h200),'h200,'hFFFFFFFC,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,'hFFFFFFFC,0,dw('h200),'h200,'hFFFFFFFC,0));
        vecs.push_back(mk(0,1,1,dw('hFFFFFFFC),1,0,0, 0,'hFFFFFFFC,0,dw('h200),'hFFFFFFFC,0,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,0,1,dw('hFFFFFFFC),'hFFFFFFFC,0,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,0,0,dw('hFFFFFFFC),'hFFFFFFFC,0,0));
        // Reset while in WAIT, then a late response is ignored
        vecs.push_back(mk(1,0,0,0,1,0,0,            0,0,0,dw('hFFFFFFFC),0,0,0));
        vecs.push_back(mk(0,0,1,'h55,1,0,0,         1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,            1,0,0,0,0,0,0));
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs.push_back(mk(0,1,0,0,1,1,'h102,        1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,'h77,1,1,'h40,      0,0,0,0,0,0,1));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,0,0,0,0,0,1));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0,0,1,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,            1,0,0,0,0,0,0));
`else
        vecs.push_back(mk(0,1,0,0,1,1,'h102,        1,0,0,0,0,'h100,0));
        vecs.push_back(mk(0,1,1,'h77,1,0,0,         0,'h100,0,0,0,'h100,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            1,'h100,0,0,0,'h100,0));
        vecs.push_back(mk(0,1,1,dw('h100),1,0,0,    0,'h100,0,0,'h100,'h104,0));
        vecs.push_back(mk(0,1,0,0,1,0,0,            0,'h104,1,dw('h100),'h100,'h104,0));
`endif

        apply_stimulus(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], i);
        end

        // Throughput: 1-cycle memory, decode always ready, one request every 3 cycles
        @(negedge clk);
        apply_stimulus(mk(1,0,0,0,1,0,0, 0,0,0,0,0,0,0));
        @(negedge clk);
        reset              = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        n_acc     = 0;
        n_hand    = 0;
        pend      = 1'b0;
        pend_addr = '0;
        for (int cyc = 0; cyc < 30 && (n_acc < 3 || n_hand < 3); cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.imem_rsp_valid = pend;
            bus.imem_rsp_data  = dw(pend_addr);
            #1;
            if (bus.imem_req_valid && n_acc < 3) begin
                acc_addr[n_acc] = bus.imem_addr;
                acc_cyc[n_acc]  = cyc;
                n_acc++;
            end
            if (bus.instr_valid && n_hand < 3) begin
                hand_pc[n_hand] = bus.instr_pc;
                check_value($sformatf("handoff%0d_data", n_hand), bus.instr_data, dw(bus.instr_pc));
                n_hand++;
            end
            pend      = bus.imem_req_valid;
            pend_addr = bus.imem_addr;
        end
        check_value("throughput_accepts", n_acc, 3);
        check_value("throughput_handoffs", n_hand, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < n_acc) begin
                check_value($sformatf("req%0d_addr", i), acc_addr[i], 4 * i);
                if (i > 0)
                    check_value($sformatf("req%0d_spacing", i), acc_cyc[i] - acc_cyc[i-1], 3);
            end
            if (i < n_hand)
                check_value($sformatf("handoff%0d_pc", i), hand_pc[i], 4 * i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
